hour_units_counter: RTL and testbench

//  Hours-units digit (0-9) of the 24-hour clock, directly upstream of the
//  mod-3 hours-tens counter. Wraps at 9, or at 3 when tens==2, so

---
 rtl/hour_units_counter.sv | 150 +++++++++++++++
 tb/tb_hour_units_counter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hour_units_counter.sv
// Hours-units BCD digit of a 24-hour clock with a debounced manual-set button.
// Define HOUR_UNITS_AUTOREPEAT_EN to enable auto-repeat stepping while the button is held.
module hour_units_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       ncr,
  input  logic       en,
  input  logic       set_mode,
  input  logic       set_btn,
  input  logic [3:0] tens,
  output logic [3:0] q,
  output logic       co
);

  localparam int unsigned MaxA   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES
                                                                     : REPEAT_DELAY;
  localparam int unsigned MaxCyc = (MaxA > REPEAT_PERIOD) ? MaxA : REPEAT_PERIOD;
  localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

  typedef enum logic [2:0] {StIdle, StArm, StPressed, StHeld, StRelease} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic              sync1_q, sync2_q;
  logic              set_mode_q;
  logic [3:0]        units_q, units_d;
  logic              step;
  logic              inc;
  logic              at_max;
  logic              sync_btn;
`ifdef HOUR_UNITS_AUTOREPEAT_EN
  logic              rep_q, rep_d;
`endif

  assign sync_btn = sync2_q;

  always_ff @(posedge clk or negedge ncr) begin
    if (!ncr) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      set_mode_q <= 1'b0;
      state_q    <= StIdle;
      cnt_q      <= '0;
      units_q    <= 4'd0;
`ifdef HOUR_UNITS_AUTOREPEAT_EN
      rep_q      <= 1'b0;
`endif
    end else begin
      sync1_q    <= set_btn;
      sync2_q    <= sync1_q;
      set_mode_q <= set_mode;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      units_q    <= units_d;
`ifdef HOUR_UNITS_AUTOREPEAT_EN
      rep_q      <= rep_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step    = 1'b0;
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CntW'(1);
`ifdef HOUR_UNITS_AUTOREPEAT_EN
    rep_d   = rep_q;
`endif
    if (!set_mode) begin
      state_d = StIdle;
      cnt_d   = '0;
`ifdef HOUR_UNITS_AUTOREPEAT_EN
      rep_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          // A button already held when set mode is entered must be released first.
          if (sync_btn) begin
            state_d = set_mode_q ? StArm : StHeld;
            cnt_d   = '0;
          end
        end
        StArm: begin
          if (!sync_btn) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
            if (32'(cnt_inc) >= DEBOUNCE_CYCLES) state_d = StPressed;
          end
        end
        StPressed: begin
          step    = 1'b1;
          state_d = StHeld;
          cnt_d   = '0;
`ifdef HOUR_UNITS_AUTOREPEAT_EN
          rep_d   = 1'b0;
`endif
        end
        StHeld: begin
          if (!sync_btn) begin
            state_d = StRelease;
            cnt_d   = '0;
          end else begin
`ifdef HOUR_UNITS_AUTOREPEAT_EN
            cnt_d = cnt_inc;
            if (32'(cnt_inc) >= (rep_q ? REPEAT_PERIOD : REPEAT_DELAY)) begin
              step  = 1'b1;
              cnt_d = '0;
              rep_d = 1'b1;
            end
`endif
          end
        end
        StRelease: begin
          if (sync_btn) begin
            state_d = StHeld;
            cnt_d   = '0;
`ifdef HOUR_UNITS_AUTOREPEAT_EN
            rep_d   = 1'b0;
`endif
          end else begin
            cnt_d = cnt_inc;
            if (32'(cnt_inc) >= DEBOUNCE_CYCLES) state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Combinational carry lets the tens stage update on the same edge as the wrap.
  always_comb begin
    inc     = set_mode ? step : en;
    at_max  = (tens == 4'd2) ? (units_q >= 4'd3) : (units_q >= 4'd9);
    co      = inc & at_max;
    units_d = units_q;
    if (inc) units_d = at_max ? 4'd0 : units_q + 4'd1;
  end

  assign q = units_q;

endmodule

// File: tb/tb_hour_units_counter.sv
// Directed bench for hour_units_counter with a cycle-level reference model of
// the debounced button and the digit counter.
module tb_hour_units_counter;

  localparam int unsigned D  = 4;
  localparam int unsigned RD = 20;
  localparam int unsigned RP = 8;

  logic       clk;
  logic       ncr;
  logic       en;
  logic       set_mode;
  logic       set_btn;
  logic [3:0] tens;
  logic [3:0] q;
  logic       co;
  logic       co_seen;

  int n_cmp  = 0;
  int n_fail = 0;

  hour_units_counter #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk     (clk),
    .ncr     (ncr),
    .en      (en),
    .set_mode(set_mode),
    .set_btn (set_btn),
    .tens    (tens),
    .q       (q),
    .co      (co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: debounced level from run lengths of the synchronised button.
  int m_q     = 0;
  int m_run   = 0;
  int m_j     = 0;
  bit m_b1    = 0;
  bit m_b2    = 0;
  bit m_lvl   = 0;
  bit m_pend  = 0;
  bit m_pmode = 0;

  always @(negedge clk) begin
    bit s, stp, inc, atmax;
    int lim;
    if (!ncr) begin
      m_q = 0; m_run = 0; m_j = 0; m_b1 = 0; m_b2 = 0;
      m_lvl = 0; m_pend = 0; m_pmode = 0;
      check("rst_q", 32'(q), 0);
      check("rst_co", 32'(co), 0);
    end else begin
      s   = m_b2;
      stp = 0;
      if (!set_mode) begin
        m_lvl = 0; m_run = 0; m_pend = 0; m_j = 0;
      end else if (!m_pmode) begin
        if (s) begin
          m_lvl = 1; m_run = 0; m_j = 0;
        end
      end else if (m_pend) begin
        stp = 1; m_pend = 0; m_j = 0; m_run = 0;
      end else if (!m_lvl) begin
        if (s) begin
          m_run++;
          if (m_run == D + 1) begin
            m_lvl = 1; m_run = 0; m_pend = 1;
          end
        end else begin
          m_run = 0;
        end
      end else begin
        if (!s) begin
          m_j = 0;
          m_run++;
          if (m_run == D + 1) begin
            m_lvl = 0; m_run = 0;
          end
        end else if (m_run > 0) begin
          m_run = 0; m_j = 0;
        end else begin
          m_j++;
`ifdef HOUR_UNITS_AUTOREPEAT_EN
          if (m_j == RD || (m_j > RD && (m_j - RD) % RP == 0)) stp = 1;
`endif
        end
      end
      lim   = (tens == 4'd2) ? 3 : 9;
      inc   = set_mode ? stp : en;
      atmax = (m_q >= lim);
      check("cyc_q", 32'(q), 32'(m_q));
      check("cyc_co", 32'(co), 32'(inc && atmax));
      if (inc) m_q = atmax ? 0 : m_q + 1;
      m_pmode = set_mode;
      m_b2    = m_b1;
      m_b1    = set_btn;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int n);
    repeat (n) begin
      en = 1'b1;
      cyc(1);
      en = 1'b0;
      cyc(1);
    end
  endtask

  task automatic btn(input logic v, input int n);
    set_btn = v;
    cyc(n);
  endtask

  initial begin
    ncr = 1'b0; en = 1'b0; set_mode = 1'b0; set_btn = 1'b0; tens = 4'd0;
    cyc(2);
    ncr = 1'b1;
    check("reset_q", 32'(q), 0);
    check("reset_co", 32'(co), 0);

    // Ten minute-carry ticks walk 0..9 and wrap with a carry.
    tens = 4'd1;
    for (int i = 1; i <= 10; i++) begin
      en = 1'b1;
      #2;
      check("count_co", 32'(co), (i == 10) ? 1 : 0);
      cyc(1);
      en = 1'b0;
      check("count_q", 32'(q), 32'(i % 10));
      cyc(1);
    end

    // Asynchronous reset mid-count.
    pulse(7);
    check("pre_reset_q", 32'(q), 7);
    #2 ncr = 1'b0;
    #1;
    check("async_rst_q", 32'(q), 0);
    check("async_rst_co", 32'(co), 0);
    cyc(2);
    ncr = 1'b1;

    // 23 -> 00 wrap of the units digit.
    tens = 4'd2;
    pulse(3);
    check("at23_q", 32'(q), 3);
    en = 1'b1;
    #2;
    check("wrap_co", 32'(co), 1);
    cyc(1);
    en = 1'b0;
    check("wrap_q", 32'(q), 0);
    cyc(1);

    // Full day with a tens stage closing the loop.
    tens = 4'd0;
    for (int i = 0; i < 24; i++) begin
      en = 1'b1;
      #2;
      co_seen = co;
      cyc(1);
      en = 1'b0;
      if (co_seen) tens = (tens == 4'd2) ? 4'd0 : tens + 4'd1;
      check("hour", 32'(tens) * 10 + 32'(q), 32'((i + 1) % 24));
      cyc(1);
    end

    // Bouncy press then stable hold: one step 5 -> 6; bouncy release: none.
    tens = 4'd1;
    pulse(5);
    set_mode = 1'b1;
    cyc(1);
    btn(1'b1, 1); btn(1'b0, 2); btn(1'b1, 2); btn(1'b0, 1);
    btn(1'b1, 3); btn(1'b0, 2); btn(1'b1, 30);
    check("debounce_q", 32'(q), 6);
    btn(1'b0, 2); btn(1'b1, 1); btn(1'b0, 3); btn(1'b1, 2); btn(1'b0, 20);
    check("release_q", 32'(q), 6);

    // en ignored in set mode.
    for (int i = 0; i < 5; i++) begin
      en = 1'b1;
      #2;
      check("excl_co", 32'(co), 0);
      cyc(1);
      en = 1'b0;
      cyc(1);
    end
    check("excl_q", 32'(q), 6);

    // set_mode dropped while arming, then re-entered with the button still held.
    btn(1'b1, 4);
    set_mode = 1'b0;
    cyc(1);
    set_mode = 1'b1;
    cyc(20);
    btn(1'b0, 10);
    check("drop_arm_q", 32'(q), 6);

    // Long hold from 0 with tens=0.
    set_mode = 1'b0;
    pulse(4);
    check("pre_hold_q", 32'(q), 0);
    tens = 4'd0;
    set_mode = 1'b1;
    cyc(1);
    btn(1'b1, 60);
    btn(1'b0, 20);
`ifdef HOUR_UNITS_AUTOREPEAT_EN
    check("hold_q", 32'(q), 6);
`else
    check("hold_q", 32'(q), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
